// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: sequential word fetch over req/ack into a
// small FIFO, with redirect flush and a sticky underflow flag.
module instr_prefetch #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int LVL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  input  logic              rd_instr,
  output logic [31:0]       instrn,
  output logic              instrn_valid,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] pc_inc;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [31:0]       fifo_q [DEPTH];
  logic              pop;
  logic              push;
  logic [LVL_W-1:0]  lvl_pop;

  assign instrn_valid = (fifo_level != '0);
  assign instrn  = instrn_valid ? fifo_q[rd_ptr] : 32'h0;
  assign pop     = rd_instr && instrn_valid;
  assign lvl_pop = fifo_level - LVL_W'(pop);
  assign mem_req = (state != IDLE);
  assign pc_inc  = fetch_pc + ADDR_W'(1);

  always_comb begin
    state_d = state;
    pc_d    = fetch_pc;
    addr_d  = mem_addr;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_addr;
        end else if (lvl_pop < FULL) begin
          state_d = FETCH;
          addr_d  = fetch_pc;
        end
      end
      FETCH: begin
        if (redirect) begin
          // Word in flight belongs to the old stream.
          pc_d = redirect_addr;
          if (mem_ack) addr_d = redirect_addr;
          else state_d = DRAIN;
        end else if (mem_ack) begin
          push = 1'b1;
          pc_d = pc_inc;
          if ((lvl_pop + LVL_W'(1)) < FULL) addr_d = pc_inc;
          else state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_addr;
        if (mem_ack) begin
          state_d = FETCH;
          addr_d  = pc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= '0;
      mem_addr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      underflow  <= 1'b0;
    end else begin
      state    <= state_d;
      fetch_pc <= pc_d;
      mem_addr <= addr_d;
      if (rd_instr && !instrn_valid) underflow <= 1'b1;
      if (redirect) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        fifo_level <= lvl_pop + LVL_W'(push);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) fifo_q[wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rd_instr;
  logic [31:0] instrn;
  logic        instrn_valid;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [2:0]  fifo_level;
  logic        underflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  bit          m_pend;
  bit          m_drop;
  bit          m_uf;
  logic [7:0]  m_paddr;
  logic [7:0]  m_npc;
  logic [7:0]  seen[$];

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(4), .ADDR_W(8), .LVL_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .rd_instr(rd_instr),
    .instrn(instrn),
    .instrn_valid(instrn_valid),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .fifo_level(fifo_level),
    .underflow(underflow)
  );

  // Drive one cycle of inputs, advance the model, wait for the next negedge.
  task automatic step(input bit rst, input bit ack, input bit rd,
                      input bit rdr, input logic [7:0] ra,
                      input bit fixed, input logic [31:0] d);
    logic [31:0] w;
    bit acked;
    w = fixed ? d : (32'hA000_0000 | {24'h0, m_paddr});
    reset = rst;
    mem_ack = ack;
    rd_instr = rd;
    redirect = rdr;
    redirect_addr = ra;
    mem_rdata = w;
    if (rst) begin
      mq.delete();
      m_pend = 0;
      m_drop = 0;
      m_uf = 0;
      m_npc = 8'h00;
      m_paddr = 8'h00;
    end else begin
      acked = m_pend && ack;
      if (rd) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_uf = 1;
      end
      if (acked && !m_drop && !rdr) begin
        mq.push_back(w);
        m_npc = m_npc + 8'd1;
      end
      if (rdr) begin
        mq.delete();
        m_npc = ra;
      end
      if (m_pend && !ack) begin
        if (rdr) m_drop = 1;
      end else if (acked) begin
        m_drop = 0;
        m_pend = mq.size() < DEPTH;
        m_paddr = m_npc;
      end else begin
        m_pend = !rdr && (mq.size() < DEPTH);
        m_paddr = m_npc;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 0, 8'h00, 0, 0);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h00 || fifo_level !== 3'd0 ||
        instrn_valid !== 1'b0 || instrn !== 32'h0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset req=%b addr=%h lvl=%0d v=%b ins=%h uf=%b exp all 0",
               mem_req, mem_addr, fifo_level, instrn_valid, instrn, underflow);
    end
  endtask

  task automatic test_fill();
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      if (mem_req === 1'b1) seen.push_back(mem_addr);
      step(0, 1, 0, 0, 8'h00, 0, 0);
    end
    checks++;
    if (seen.size() != 4) begin
      errors++;
      $display("FAIL fill_count got=%0d exp=4", seen.size());
    end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      checks++;
      if (seen[i] !== 8'(i)) begin
        errors++;
        $display("FAIL fill_addr[%0d] got=%h exp=%h", i, seen[i], 8'(i));
      end
    end
    checks++;
    if (fifo_level !== 3'd4 || mem_req !== 1'b0 || instrn !== 32'hA000_0000) begin
      errors++;
      $display("FAIL fill_end lvl=%0d req=%b ins=%h exp 4 0 a0000000",
               fifo_level, mem_req, instrn);
    end
  endtask

  task automatic test_pop_refill();
    seen.delete();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instrn !== 32'hA000_0000 + i) begin
        errors++;
        $display("FAIL pop_word[%0d] got=%h exp=%h", i, instrn,
                 32'hA000_0000 + i);
      end
      if (mem_req === 1'b1) seen.push_back(mem_addr);
      step(0, 1, 1, 0, 8'h00, 0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1) seen.push_back(mem_addr);
      step(0, 1, 0, 0, 8'h00, 0, 0);
    end
    checks++;
    if (seen.size() != 4 || seen[0] !== 8'h04 || seen[3] !== 8'h07) begin
      errors++;
      $display("FAIL refill_addrs got n=%0d exp 4 fetches 04..07", seen.size());
    end
    checks++;
    if (fifo_level !== 3'd4 || mem_req !== 1'b0 || instrn !== 32'hA000_0004) begin
      errors++;
      $display("FAIL refill_end lvl=%0d req=%b ins=%h exp 4 0 a0000004",
               fifo_level, mem_req, instrn);
    end
  endtask

  task automatic test_slow_ack();
    step(0, 0, 0, 1, 8'h10, 0, 0);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h10 + 8'(k) ||
            fifo_level !== 3'(k)) begin
          errors++;
          $display("FAIL slow_wait k=%0d w=%0d req=%b addr=%h lvl=%0d exp 1 %h %0d",
                   k, w, mem_req, mem_addr, fifo_level, 8'h10 + 8'(k), k);
        end
        step(0, (w == 3), 0, 0, 8'h00, 0, 0);
      end
    end
  endtask

  task automatic test_redirect_drain();
    step(0, 0, 0, 1, 8'h40, 0, 0);
    checks++;
    if (fifo_level !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 8'h13) begin
      errors++;
      $display("FAIL drain_hold lvl=%0d req=%b addr=%h exp 0 1 13",
               fifo_level, mem_req, mem_addr);
    end
    step(0, 0, 0, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 1, 32'hDEAD_BEEF);
    checks++;
    if (fifo_level !== 3'd0 || instrn_valid !== 1'b0 || instrn !== 32'h0 ||
        mem_req !== 1'b1 || mem_addr !== 8'h40) begin
      errors++;
      $display("FAIL drain_discard lvl=%0d v=%b ins=%h req=%b addr=%h exp 0 0 0 1 40",
               fifo_level, instrn_valid, instrn, mem_req, mem_addr);
    end
    step(0, 1, 0, 0, 8'h00, 0, 0);
    checks++;
    if (fifo_level !== 3'd1 || instrn !== 32'hA000_0040) begin
      errors++;
      $display("FAIL drain_resume lvl=%0d ins=%h exp 1 a0000040",
               fifo_level, instrn);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_a [4];
    exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    step(0, 1, 0, 1, 8'hFE, 0, 0);
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      if (mem_req === 1'b1) seen.push_back(mem_addr);
      step(0, 1, 0, 0, 8'h00, 0, 0);
    end
    checks++;
    if (seen.size() != 4 || fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL wrap_count got=%0d lvl=%0d exp 4 4", seen.size(), fifo_level);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= seen.size() || seen[i] !== exp_a[i] ||
          instrn !== (32'hA000_0000 | {24'h0, exp_a[i]})) begin
        errors++;
        $display("FAIL wrap[%0d] ins=%h exp addr %h", i, instrn, exp_a[i]);
      end
      step(0, 0, 1, 0, 8'h00, 0, 0);
    end
  endtask

  task automatic test_underflow();
    step(1, 0, 0, 0, 8'h00, 0, 0);
    step(0, 0, 1, 0, 8'h00, 0, 0);
    checks++;
    if (underflow !== 1'b1 || instrn !== 32'h0) begin
      errors++;
      $display("FAIL underflow_set uf=%b ins=%h exp 1 0", underflow, instrn);
    end
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 1, 1, 0, 8'h00, 0, 0);
    step(0, 1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 0, 8'h00, 0, 0);
    checks++;
    if (underflow !== 1'b1 || mem_req !== 1'b1 || fifo_level !== 3'd2) begin
      errors++;
      $display("FAIL underflow_sticky uf=%b req=%b lvl=%0d exp 1 1 2",
               underflow, mem_req, fifo_level);
    end
    step(1, 0, 0, 0, 8'h00, 0, 0);
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 8'h00 || fifo_level !== 3'd0 ||
        instrn_valid !== 1'b0 || instrn !== 32'h0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_reset req=%b addr=%h lvl=%0d v=%b ins=%h uf=%b exp 0",
               mem_req, mem_addr, fifo_level, instrn_valid, instrn, underflow);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0, 8'h00, 0, 0);
    for (int c = 0; c < 10; c++) begin
      step(0, 1, 1, 0, 8'h00, 0, 0);
      if (c >= 1) begin
        checks++;
        if (instrn_valid !== 1'b1 || instrn !== 32'hA000_0000 + (c - 1)) begin
          errors++;
          $display("FAIL b2b[%0d] v=%b ins=%h exp 1 %h", c, instrn_valid,
                   instrn, 32'hA000_0000 + (c - 1));
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e_ins;
    step(1, 0, 0, 0, 8'h00, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      e_ins = (mq.size() > 0) ? mq[0] : 32'h0;
      checks++;
      if (mem_req !== m_pend || (m_pend && mem_addr !== m_paddr) ||
          fifo_level !== 3'(mq.size()) || instrn_valid !== (mq.size() > 0) ||
          instrn !== e_ins || underflow !== m_uf) begin
        errors++;
        $display("FAIL rand[%0d] req=%b/%b addr=%h/%h lvl=%0d/%0d ins=%h/%h uf=%b/%b",
                 n, mem_req, m_pend, mem_addr, m_paddr, fifo_level, mq.size(),
                 instrn, e_ins, underflow, m_uf);
      end
      step(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
           8'($urandom), 1, $urandom);
    end
  endtask

  initial begin
    reset = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    rd_instr = 1'b0;
    redirect = 1'b0;
    redirect_addr = 8'h00;
    @(negedge clk);
    test_reset();
    test_fill();
    test_pop_refill();
    test_slow_ack();
    test_redirect_drain();
    test_wrap();
    test_underflow();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch.md
Name: instr_prefetch

Overview:
- Instruction fetch and prefetch stage that sits directly upstream of the RISC core.
- Issues sequential 8-bit word addresses to instruction memory over a req/ack handshake and buffers the returned 32-bit words in a small FIFO.
- Presents the FIFO head on instrn, which the core consumes with its rd_instr strobe.
- A redirect input (branch, call or return target) flushes the buffer and restarts fetch at a new address.

Parameters:
- DEPTH, 4, number of FIFO entries; power of 2, range 2..16.
- ADDR_W, 8, fetch address width; matches the core program counter width.
- LVL_W, 3, width of fifo_level; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  fetch request to instruction memory; held high until mem_ack.
- mem_addr  out  ADDR_W  word address of the current request; stable while mem_req is high.
- mem_ack  in  1  memory accepts the request and returns mem_rdata in the same cycle.
- mem_rdata  in  32  instruction word; sampled only when mem_req and mem_ack are both high.
- rd_instr  in  1  core consumes the word on instrn this cycle.
- instrn  out  32  FIFO head word; 32'h0 when the FIFO is empty.
- instrn_valid  out  1  FIFO is non-empty.
- redirect  in  1  one-cycle pulse: flush the FIFO and restart fetch at redirect_addr.
- redirect_addr  in  ADDR_W  new fetch address; sampled when redirect is high.
- fifo_level  out  LVL_W  number of valid entries in the FIFO (0..DEPTH).
- underflow  out  1  sticky flag: rd_instr was seen while the FIFO was empty.

Behaviour:
- Reset: synchronous, active-high. In the same edge it clears mem_req, mem_addr, fetch_pc, instrn_valid, fifo_level, underflow, both FIFO pointers, and sets state=IDLE. This applies mid-transfer too; any outstanding request is abandoned and memory must tolerate that.
- instrn and instrn_valid are driven combinationally from the head entry (zero latency). The core samples instrn in the same cycle it raises rd_instr.
- Pop: occurs on rd_instr && instrn_valid. rd_instr && !instrn_valid sets underflow (cleared only by reset); no pointer change.
- Push: occurs on mem_req && mem_ack in state FETCH. The word is written at the tail, then fetch_pc increments modulo 2^ADDR_W (8'hFF wraps to 8'h00).
- At most one outstanding request. A request may start only when fifo_level < DEPTH, so a push can never overflow.
- Simultaneous push and pop: fifo_level is unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: mem_req=0. Go to FETCH when fifo_level < DEPTH (counted after any same-cycle pop) and no redirect is present. On redirect, load fetch_pc and stay in IDLE; FETCH starts the next cycle if there is room.
  - FETCH: mem_req=1, mem_addr=fetch_pc. On ack, push the word; then go to FETCH again if post-push level < DEPTH, else IDLE.
  - FETCH with redirect and no ack: go to DRAIN; fetch_pc is loaded with redirect_addr.
  - FETCH with redirect and ack in the same cycle: discard mem_rdata, load fetch_pc, go to FETCH (new address on the next cycle).
  - DRAIN: mem_req stays 1 with the old mem_addr until ack. Returned data is discarded, then go to FETCH at fetch_pc. A further redirect in DRAIN overwrites fetch_pc; the last redirect wins.
- Flush on redirect: fifo_level becomes 0 and the pointers reset at the end of the redirect cycle. If rd_instr coincides with redirect, the head word is still presented and consumed that cycle; flush applies after.
- mem_addr only changes on a cycle after an ack or when leaving IDLE; it never changes while mem_req is high and ack is low.
- Throughput: with mem_ack tied high and continuous rd_instr, one word is delivered per cycle after a 2-cycle startup (IDLE→FETCH, then push).

Test Plan:
- Reset, then mem_ack tied 1 with mem_rdata = 32'hA000_0000 + addr and no rd_instr → addresses 0,1,2,3 are fetched, fifo_level=4, mem_req drops to 0, instrn=32'hA000_0000.
- From full, pulse rd_instr 4 times → instrn reads A000_0000..A000_0003 in order and one new fetch at addr 4 per pop. With ack held 1, fifo_level settles back at 4.
- mem_ack delayed 3 cycles per request → mem_addr and mem_req are stable throughout each wait, and there is never more than one outstanding request.
- Redirect to 8'h40 while in FETCH with ack low; ack arrives 2 cycles later carrying 32'hDEAD_BEEF → the word is discarded, fifo_level=0, the next request is at addr 8'h40.
- redirect_addr=8'hFE with continuous ack → addresses FE, FF, 00, 01 are fetched (wrap-around).
- rd_instr asserted with FIFO empty right after reset → underflow=1 and instrn=0; underflow persists until reset. Then assert reset in the middle of a FETCH wait → all outputs return to zero on the next edge.
